phy_lane_serdes: RTL
====================

# phy_lane_serdes

Parametrised single-clock successor to `phy`. Stripes a word of `8*LANES` bits across `LANES` serial lanes, one byte per lane per 8-cycle word period, and recovers words on the receive side. The receive side aligns on 0xBC idle commas and declares the link active after four consecutive commas. It sits between the word-level logic and the serial channel. The bench ties `ser_out` to `ser_in`, directly or through delay registers.

## Interface
- `LANES`, default 4: number of serial lanes, legal 1..8.
- `DATA_W` is a localparam fixed at `8*LANES`; it is not overridable.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `data_in` in `DATA_W`: transmit word; byte k is `data_in[8k+7:8k]` and goes to lane k.
- `valid_in` in 1: transmit word valid; sampled together with `data_in`.
- `tx_ready` out 1: high one cycle in every 8; `data_in` and `valid_in` are sampled in that cycle.
- `ser_out` out `LANES`: serial transmit, one bit per lane per cycle, MSB first.
- `ser_in` in `LANES`: serial receive; all lanes must be skew-free with respect to each other.
- `data_out` out `DATA_W`: received word, held for 8 cycles.
- `valid_out` out 1: `data_out` holds a data word; low for idle words or while not active.
- `rx_strobe` out 1: one-cycle pulse whenever `data_out` and `valid_out` update.
- `active` out 1: receiver aligned.

## Operation
- **TX shift registers**
  - Each lane has an 8-bit shift register; `ser_out[k] = sh[k][7]`.
  - A 3-bit counter runs 0..7; `tx_ready = (cnt == 7)`.
  - On the `tx_ready` edge: if `valid_in` is 1, load byte k into lane k; otherwise load 0xBC into every lane. On all other edges, shift left by one.
- **Idle word**: all bytes equal to 0xBC. A data word in which every byte is 0xBC is reserved; it is transmitted but received with `valid_out` = 0.
- **RX shift registers**: each lane has an 8-bit register, updated every cycle as `rsh[k] <= {rsh[k][6:0], ser_in[k]}`.
- **RX FSM** (3-bit phase counter, 2-bit comma counter):
  - SEARCH: each cycle, test lane 0 `rsh == 0xBC`. On a hit, clear the phase counter, set comma count to 1 and go to COUNT.
  - COUNT: the phase counter wraps every 8 cycles; each wrap is a boundary. At a boundary, if lane 0 `== 0xBC`, increment the comma count; on reaching 4, go to ACTIVE. If lane 0 is not 0xBC, go to SEARCH; searching resumes on the next cycle.
  - ACTIVE: at each boundary, capture `{rsh[LANES-1],…,rsh[0]}` into `data_out` and pulse `rx_strobe`. `valid_out` = 0 if all lanes are 0xBC, else 1. There is no exit except `reset`.
- Outside ACTIVE, `valid_out` = 0, `data_out` holds its last value, and `rx_strobe` = 0.
- **Comma immunity**: in a continuous 0xBC stream, 0xBC appears only at the byte phase, so the stream gives no false lock.

## Timing
- **Reset values** (on the edge where `reset` = 1):
  - TX counter = 0; every TX shift register = 0xBC, so idle is sent from the first cycle after reset.
  - FSM = SEARCH; counters = 0.
  - `data_out` = 0; `valid_out`, `rx_strobe`, `active`, `tx_ready` = 0.
- Cycle 0 is the first cycle with `reset` low. `tx_ready` is high in cycles 7, 15, 23, …
- A word sampled in cycle T drives `ser_out` in cycles T+1..T+8, MSB in T+1.
- **Latency**, with a direct wire `ser_out` → `ser_in`: `data_out`, `valid_out` and `rx_strobe` update in cycle T+10. Each external delay register adds 1.
- **Lock time**, direct wire: first comma detected in cycle 8; boundaries fall in cycles 16, 24 and 32; `active` = 1 from cycle 33.
- **Reset mid-operation**: all state returns to reset values on the next edge. TX restarts idle and RX relocks after 33 cycles.

## Configuration
- `PHY_LOOPBACK_EN` defined:
  - Adds input port `loopback` (1 bit).
  - When `loopback` = 1, RX takes `ser_out` internally with zero delay instead of `ser_in`.
  - Switching `loopback` while active gives undefined data until `reset`.
- `PHY_LOOPBACK_EN` undefined: no `loopback` port; RX always takes `ser_in`.

## Test plan
- Reset, `valid_in` = 0, direct wire → `active` rises in cycle 33; `valid_out` stays 0 and `rx_strobe` pulses every 8 cycles from cycle 41.
- `LANES` = 4; `data_in` = 0x12345678 at the first `tx_ready` after `active` → lane 0 serial bits are 0x78 MSB first; 10 cycles later `data_out` = 0x12345678 with `valid_out` = 1.
- Back-to-back words 0xA5A5A5A5, 0x0000FFFF, then `valid_in` = 0 → both words are received in order 8 cycles apart, then `valid_out` = 0 with `data_out` = 0xBCBCBCBC.
- Hold `ser_in[0]` = 0 through cycle 40 → `active` stays 0 and asserts 33 cycles after the first comma reaches `ser_in[0]`.
- One delay register on all lanes, `LANES` = 2 → lock succeeds and `data_out` latency is 11 cycles; 0xBEEF is received intact.
- Assert `reset` mid-word in ACTIVE → next edge all outputs take reset values; `active` returns at cycle 33 after release; with `PHY_LOOPBACK_EN` and `loopback` = 1 and `ser_in` tied 0, the same results hold.

Source files
------------

// File: rtl/phy_lane_serdes.sv
// Multi-lane byte serialiser/deserialiser with 0xBC comma alignment on lane 0.
// Optional feature macro: PHY_LOOPBACK_EN adds an internal ser_out->RX loopback port.
module phy_lane_serdes #(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               reset,
`ifdef PHY_LOOPBACK_EN
  input  logic               loopback,
`endif
  input  logic [8*LANES-1:0] data_in,
  input  logic               valid_in,
  output logic               tx_ready,
  output logic [LANES-1:0]   ser_out,
  input  logic [LANES-1:0]   ser_in,
  output logic [8*LANES-1:0] data_out,
  output logic               valid_out,
  output logic               rx_strobe,
  output logic               active
);

  localparam int          DATA_W = 8 * LANES;
  localparam logic [7:0]  COMMA  = 8'hBC;

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_COUNT,
    ST_ACTIVE
  } rx_state_e;

  // ---------------------------------------------------------------------------
  // Transmit: one 8-bit shift register per lane, reloaded once per word period.
  // Handshake: there is no back-pressure. tx_ready is high for exactly one cycle
  // in every eight; data_in/valid_in are sampled only on that cycle's edge, and
  // valid_in = 0 there sends an idle word (0xBC on every lane).
  // ---------------------------------------------------------------------------
  logic [2:0]            tx_cnt_q, tx_cnt_d;
  logic [LANES-1:0][7:0] tx_sh_q, tx_sh_d;

  assign tx_ready = (tx_cnt_q == 3'd7);

  always_comb begin
    tx_cnt_d = tx_cnt_q + 3'd1;
    tx_sh_d  = tx_sh_q;
    for (int k = 0; k < LANES; k++) begin
      if (tx_ready) begin
        tx_sh_d[k] = valid_in ? data_in[8*k +: 8] : COMMA;
      end else begin
        tx_sh_d[k] = {tx_sh_q[k][6:0], 1'b0};
      end
    end
  end

  always_comb begin
    ser_out = '0;
    for (int k = 0; k < LANES; k++) begin
      ser_out[k] = tx_sh_q[k][7];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_cnt_q <= 3'd0;
      tx_sh_q  <= {LANES{COMMA}};
    end else begin
      tx_cnt_q <= tx_cnt_d;
      tx_sh_q  <= tx_sh_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive shift registers
  // ---------------------------------------------------------------------------
  logic [LANES-1:0]      rx_src;
  logic [LANES-1:0][7:0] rx_sh_q, rx_sh_d;

`ifdef PHY_LOOPBACK_EN
  assign rx_src = loopback ? ser_out : ser_in;
`else
  assign rx_src = ser_in;
`endif

  always_comb begin
    rx_sh_d = rx_sh_q;
    for (int k = 0; k < LANES; k++) begin
      rx_sh_d[k] = {rx_sh_q[k][6:0], rx_src[k]};
    end
  end

  // ---------------------------------------------------------------------------
  // Alignment FSM. The phase counter free-runs once a comma is seen; phase 7 is
  // the cycle in which a complete, byte-aligned word sits in rx_sh_q.
  // ---------------------------------------------------------------------------
  rx_state_e          rx_state_q, rx_state_d;
  logic [2:0]         phase_q, phase_d;
  logic [1:0]         comma_q, comma_d;
  logic [DATA_W-1:0]  data_out_q, data_out_d;
  logic               valid_out_q, valid_out_d;
  logic               rx_strobe_q, rx_strobe_d;
  logic               boundary;
  logic               lane0_comma;
  logic               all_comma;

  assign boundary    = (phase_q == 3'd7);
  assign lane0_comma = (rx_sh_q[0] == COMMA);
  assign all_comma   = (rx_sh_q == {LANES{COMMA}});

  always_comb begin
    rx_state_d  = rx_state_q;
    phase_d     = phase_q + 3'd1;
    comma_d     = comma_q;
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;
    rx_strobe_d = 1'b0;
    case (rx_state_q)
      ST_SEARCH: begin
        phase_d     = 3'd0;
        comma_d     = 2'd0;
        valid_out_d = 1'b0;
        if (lane0_comma) begin
          rx_state_d = ST_COUNT;
          comma_d    = 2'd1;
        end
      end
      ST_COUNT: begin
        valid_out_d = 1'b0;
        if (boundary) begin
          if (lane0_comma) begin
            // The fourth consecutive comma wraps the 2-bit count back to zero.
            comma_d = comma_q + 2'd1;
            if (comma_q == 2'd3) begin
              rx_state_d = ST_ACTIVE;
            end
          end else begin
            rx_state_d = ST_SEARCH;
            comma_d    = 2'd0;
          end
        end
      end
      ST_ACTIVE: begin
        if (boundary) begin
          data_out_d  = rx_sh_q;
          valid_out_d = !all_comma;
          rx_strobe_d = 1'b1;
        end
      end
      default: begin
        rx_state_d = ST_SEARCH;
        phase_d    = 3'd0;
        comma_d    = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sh_q     <= '0;
      rx_state_q  <= ST_SEARCH;
      phase_q     <= 3'd0;
      comma_q     <= 2'd0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      rx_strobe_q <= 1'b0;
    end else begin
      rx_sh_q     <= rx_sh_d;
      rx_state_q  <= rx_state_d;
      phase_q     <= phase_d;
      comma_q     <= comma_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      rx_strobe_q <= rx_strobe_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign rx_strobe = rx_strobe_q;
  assign active    = (rx_state_q == ST_ACTIVE);

endmodule
